// File: rtl/pre_cal_seq.sv
//==============================================================================
// Module      : pre_cal_seq
// Description : Sequenced MMSE pre-calculation engine for a 4x4 MIMO detector.
//               Computes A = H^T*H + snr*I and b = H^T*r with a single shared
//               multiply-accumulate unit, one MAC per cycle.
//               Optional macro PRE_CAL_SYM_EN: compute only the upper triangle
//               of A and mirror each off-diagonal entry into the lower one.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pre_cal_seq (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [0:3][0:3][31:0]  H_matrix,
    input  logic [0:3][31:0]       signal_receive,
    input  logic [31:0]            snr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [0:3][0:3][31:0]  matrix_A,
    output logic [0:3][31:0]       vector_b,
    output logic                   busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Captured problem
    logic [0:3][0:3][31:0] r_h;
    logic [0:3][31:0]      r_r;
    logic [31:0]           r_snr;

    // Results
    logic [0:3][0:3][31:0] r_a;
    logic [0:3][31:0]      r_b;

    // Sequencing: (r_i, r_j) is the A entry, or r_i is the b index in b phase
    logic [1:0]  r_i;
    logic [1:0]  r_j;
    logic [1:0]  r_k;
    logic        r_phase_b;
    logic [31:0] r_acc;

    logic [31:0] w_a;
    logic [31:0] w_x;
    logic [31:0] w_prod;
    logic [31:0] w_sum;
    logic        w_diag;
    logic        w_last;
    logic [1:0]  w_i_next;
    logic [1:0]  w_j_next;
    logic        w_phase_b_next;

    // Shared MAC: column i of H dotted with column j of H, or with r
    assign w_a    = r_h[r_k][r_i];
    assign w_x    = r_phase_b ? r_r[r_k] : r_h[r_k][r_j];
    assign w_prod = w_a * w_x;
    assign w_sum  = r_acc + w_prod;
    assign w_diag = !r_phase_b && (r_i == r_j);
    assign w_last = r_phase_b && (r_i == 2'd3) && (r_k == 2'd3);

    assign matrix_A = r_a;
    assign vector_b = r_b;

    // Entry order advance: A row-major (upper triangle only when mirrored), then b
    always_comb begin
        w_i_next       = r_i;
        w_j_next       = r_j;
        w_phase_b_next = r_phase_b;
        if (r_phase_b) begin
            w_i_next = r_i + 2'd1;
        end else if (r_j == 2'd3) begin
            if (r_i == 2'd3) begin
                w_phase_b_next = 1'b1;
                w_i_next       = 2'd0;
                w_j_next       = 2'd0;
            end else begin
                w_i_next = r_i + 2'd1;
`ifdef PRE_CAL_SYM_EN
                w_j_next = r_i + 2'd1;
`else
                w_j_next = 2'd0;
`endif
            end
        end else begin
            w_j_next = r_j + 2'd1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and handshake outputs, decoded from state only
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        busy         = 1'b0;
        out_valid    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: capture, MAC sequencing and result write-back
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_h       <= '0;
            r_r       <= '0;
            r_snr     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_i       <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_phase_b <= 1'b0;
            r_acc     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_h       <= H_matrix;
                        r_r       <= signal_receive;
                        r_snr     <= snr;
                        r_i       <= '0;
                        r_j       <= '0;
                        r_k       <= '0;
                        r_phase_b <= 1'b0;
                        r_acc     <= '0;
                    end
                end
                S_COMPUTE: begin
                    r_k <= r_k + 2'd1;
                    if (r_k == 2'd3) begin
                        if (r_phase_b) begin
                            r_b[r_i] <= w_sum;
                        end else begin
                            r_a[r_i][r_j] <= w_diag ? (w_sum + r_snr) : w_sum;
`ifdef PRE_CAL_SYM_EN
                            if (r_i != r_j) begin
                                r_a[r_j][r_i] <= w_sum;
                            end
`endif
                        end
                        r_acc     <= '0;
                        r_i       <= w_i_next;
                        r_j       <= w_j_next;
                        r_phase_b <= w_phase_b_next;
                    end else begin
                        r_acc <= w_sum;
                    end
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pre_cal_seq.sv
`default_nettype none

module tb_pre_cal_seq;

`ifdef PRE_CAL_SYM_EN
    localparam int LAT = 56;
`else
    localparam int LAT = 80;
`endif

    logic                  clk;
    logic                  reset;
    logic                  in_valid;
    logic                  in_ready;
    logic [0:3][0:3][31:0] H_matrix;
    logic [0:3][31:0]      signal_receive;
    logic [31:0]           snr;
    logic                  out_valid;
    logic                  out_ready;
    logic [0:3][0:3][31:0] matrix_A;
    logic [0:3][31:0]      vector_b;
    logic                  busy;

    int vectors;
    int miscompares;

    logic [31:0] h_in [4][4];
    logic [31:0] r_in [4];
    logic [31:0] snr_in;
    logic [31:0] ea [4][4];
    logic [31:0] eb [4];

    pre_cal_seq dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .H_matrix       (H_matrix),
        .signal_receive (signal_receive),
        .snr            (snr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .matrix_A       (matrix_A),
        .vector_b       (vector_b),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: A = H^T H + snr I, b = H^T r, all modulo 2^32
    task automatic compute_model();
        logic [31:0] s;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = (i == j) ? snr_in : 32'd0;
                for (int k = 0; k < 4; k++) s = s + h_in[k][i] * h_in[k][j];
                ea[i][j] = s;
            end
            s = 32'd0;
            for (int k = 0; k < 4; k++) s = s + h_in[k][i] * r_in[k];
            eb[i] = s;
        end
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) H_matrix[i][j] = $urandom;
            signal_receive[i] = $urandom;
        end
        snr = $urandom;
    endtask

    task automatic set_identity();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) h_in[i][j] = (i == j) ? 32'd1 : 32'd0;
            r_in[i] = 32'(i + 1);
        end
        snr_in = 32'd5;
    endtask

    task automatic set_zero();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) h_in[i][j] = 32'd0;
            r_in[i] = 32'd0;
        end
        snr_in = 32'd0;
    endtask

    task automatic send_problem();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) H_matrix[i][j] = h_in[i][j];
            signal_receive[i] = r_in[i];
        end
        snr = snr_in;
        compute_model();
        in_valid = 1'b1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL in_ready_before_accept got %b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble_inputs();
        vectors++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL compute_flags got busy=%b in_ready=%b out_valid=%b expected 1/0/0",
                     busy, in_ready, out_valid);
        end
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (n != LAT) begin
            miscompares++;
            $display("FAIL latency got %0d edges expected %0d", n, LAT);
        end
    endtask

    task automatic check_outputs(input string name);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                vectors++;
                if (matrix_A[i][j] !== ea[i][j]) begin
                    miscompares++;
                    $display("FAIL %s A[%0d][%0d] got %h expected %h", name, i, j, matrix_A[i][j], ea[i][j]);
                end
            end
            vectors++;
            if (vector_b[i] !== eb[i]) begin
                miscompares++;
                $display("FAIL %s b[%0d] got %h expected %h", name, i, vector_b[i], eb[i]);
            end
        end
    endtask

    task automatic out_handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL after_out_handshake got in_ready=%b out_valid=%b busy=%b expected 1/0/0",
                     in_ready, out_valid, busy);
        end
    endtask

    task automatic run_full(input string name);
        send_problem();
        wait_result();
        check_outputs(name);
        out_handshake();
    endtask

    task automatic test_reset();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            matrix_A !== '0 || vector_b !== '0) begin
            miscompares++;
            $display("FAIL reset_state got in_ready=%b out_valid=%b busy=%b A_nonzero=%b b_nonzero=%b",
                     in_ready, out_valid, busy, |matrix_A, |vector_b);
        end
    endtask

    task automatic test_identity();
        set_identity();
        run_full("identity");
    endtask

    task automatic test_general();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) h_in[i][j] = 32'd2;
            r_in[i] = 32'(i + 1);
        end
        snr_in = 32'd0;
        run_full("general");
    endtask

    task automatic test_wrap();
        set_zero();
        h_in[0][0] = 32'h0001_0000;
        snr_in     = 32'd7;
        run_full("wrap");
    endtask

    task automatic test_asymmetric();
        set_zero();
        h_in[0][1] = 32'd3;
        h_in[2][1] = 32'd4;
        r_in[2]    = 32'd1;
        run_full("asym");
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) h_in[i][j] = (t < 2) ? 32'($urandom_range(0, 1000)) - 32'd500 : $urandom;
                r_in[i] = $urandom;
            end
            snr_in = $urandom;
            run_full("random");
        end
    endtask

    task automatic test_backpressure();
        set_identity();
        h_in[1][2] = 32'd9;
        h_in[3][0] = 32'hFFFF_FFFE;
        send_problem();
        wait_result();
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL backpressure_flags cycle %0d got out_valid=%b in_ready=%b expected 1/0",
                         c, out_valid, in_ready);
            end
        end
        in_valid = 1'b0;
        check_outputs("backpressure");
        out_handshake();
    endtask

    task automatic test_back_to_back();
        set_identity();
        run_full("b2b_first");
        test_general();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) h_in[i][j] = $urandom;
            r_in[i] = $urandom;
        end
        snr_in = $urandom;
        send_problem();
        repeat (39) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || matrix_A !== '0 || vector_b !== '0) begin
            miscompares++;
            $display("FAIL reset_mid got out_valid=%b busy=%b A_nonzero=%b b_nonzero=%b expected 0/0/0/0",
                     out_valid, busy, |matrix_A, |vector_b);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_in_ready got %b expected 1", in_ready);
        end
        set_identity();
        run_full("post_reset_identity");
    endtask

    initial begin
        reset       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        vectors     = 0;
        miscompares = 0;
        H_matrix       = '0;
        signal_receive = '0;
        snr            = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_identity();
        test_general();
        test_wrap();
        test_asymmetric();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
